cr_cg_rbus_arb: RTL

//  Round-robin arbiter and sequencer sharing one rbus master port among N_REQ local requesters
//  (e.g. the config loader and the debug engine) ahead of the CG register ring.

---
 rtl/cr_cg_rbus_arb_if.sv | 50 +++++
 rtl/cr_cg_rbus_arb.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cr_cg_rbus_arb_if.sv
// cr_cg_rbus_arb_if
//   Bundles the requester-side and rbus-side signals of the rbus arbiter.
//   master : view taken by the arbiter (drives rbus strobes and responses)
//   slave  : view taken by the requesters and the register ring
// Signals
//   req_vld/req_wr      [N_REQ]          per-requester valid and write flag
//   req_addr            [N_REQ*ADDR_W]   packed, slice i belongs to requester i
//   req_wdata           [N_REQ*DATA_W]   packed write data
//   rsp_vld             [N_REQ]          one-hot single-cycle response
//   rsp_err, rsp_rdata                   response status and read data
//   rbus_*_o / rbus_*_i                  rbus master port
//   busy_o, timeout_o                    status
interface cr_cg_rbus_arb_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req_vld;
  logic [N_REQ-1:0]        req_wr;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        rsp_vld;
  logic                    rsp_err;
  logic [DATA_W-1:0]       rsp_rdata;
  logic [ADDR_W-1:0]       rbus_addr_o;
  logic                    rbus_wr_strb_o;
  logic [DATA_W-1:0]       rbus_wr_data_o;
  logic                    rbus_rd_strb_o;
  logic [DATA_W-1:0]       rbus_rd_data_i;
  logic                    rbus_ack_i;
  logic                    rbus_err_ack_i;
  logic                    busy_o;
  logic                    timeout_o;

  modport master (
    input  req_vld, req_wr, req_addr, req_wdata,
    input  rbus_rd_data_i, rbus_ack_i, rbus_err_ack_i,
    output rsp_vld, rsp_err, rsp_rdata,
    output rbus_addr_o, rbus_wr_strb_o, rbus_wr_data_o, rbus_rd_strb_o,
    output busy_o, timeout_o
  );

  modport slave (
    output req_vld, req_wr, req_addr, req_wdata,
    output rbus_rd_data_i, rbus_ack_i, rbus_err_ack_i,
    input  rsp_vld, rsp_err, rsp_rdata,
    input  rbus_addr_o, rbus_wr_strb_o, rbus_wr_data_o, rbus_rd_strb_o,
    input  busy_o, timeout_o
  );
endinterface

// File: rtl/cr_cg_rbus_arb.sv
// cr_cg_rbus_arb
//   Round-robin arbiter/sequencer sharing one rbus master port among N_REQ
//   requesters. One read or write per grant: a single-cycle strobe, then a
//   bounded wait for ack/err_ack, then a one-hot response to the granted
//   requester. All outputs are registered.
// Ports
//   clk  : clock
//   rst  : synchronous reset, active-high; aborts any transaction in flight
//   bus  : cr_cg_rbus_arb_if.master (requests, responses, rbus port, status)
module cr_cg_rbus_arb #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  cr_cg_rbus_arb_if.master  bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0]   gnt, gnt_d;
  logic               wr, wr_d;
  logic [15:0]        timer, timer_d;
  logic [ADDR_W-1:0]  addr, addr_d;
  logic [DATA_W-1:0]  wdata, wdata_d;
  logic               wr_strb, wr_strb_d;
  logic               rd_strb, rd_strb_d;
  logic [N_REQ-1:0]   rsp_vld, rsp_vld_d;
  logic               rsp_err, rsp_err_d;
  logic [DATA_W-1:0]  rsp_rdata, rsp_rdata_d;
  logic               timeout, timeout_d;
  logic               pick_vld;
  logic [IDX_W-1:0]   pick;

  // First requesting index after ptr, wrapping mod N_REQ. Scanning from the
  // farthest offset down lets the nearest one overwrite the result.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] vld,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0] res;
    int idx;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx -= N_REQ;
      if (vld[idx]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    gnt_d       = gnt;
    wr_d        = wr;
    addr_d      = addr;
    wdata_d     = wdata;
    timer_d     = timer;
    wr_strb_d   = 1'b0;
    rd_strb_d   = 1'b0;
    rsp_vld_d   = '0;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
    timeout_d   = 1'b0;
    {pick_vld, pick} = rr_pick(bus.req_vld, rr_ptr);
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d     = pick;
          rr_ptr_d  = pick;
          wr_d      = bus.req_wr[pick];
          addr_d    = bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
          wdata_d   = bus.req_wdata[int'(pick)*DATA_W +: DATA_W];
          wr_strb_d = bus.req_wr[pick];
          rd_strb_d = ~bus.req_wr[pick];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Acks are only honoured here; anything seen in other states is stale.
        if (bus.rbus_ack_i || bus.rbus_err_ack_i) begin
          rsp_vld_d[gnt] = 1'b1;
          rsp_err_d      = bus.rbus_err_ack_i;
          rsp_rdata_d    = (bus.rbus_err_ack_i || wr) ? '0 : bus.rbus_rd_data_i;
          state_d        = S_RESP;
        end else if (timer == 16'(TIMEOUT - 1)) begin
          rsp_vld_d[gnt] = 1'b1;
          rsp_err_d      = 1'b1;
          rsp_rdata_d    = '0;
          timeout_d      = 1'b1;
          state_d        = S_RESP;
        end else begin
          timer_d = timer + 16'd1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Registered outputs and transaction latch; everything clears on reset so
  // an aborted transaction leaves no visible trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= IDX_W'(N_REQ - 1);
      gnt       <= '0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      timer     <= '0;
      wr_strb   <= 1'b0;
      rd_strb   <= 1'b0;
      rsp_vld   <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      timeout   <= 1'b0;
    end else begin
      rr_ptr    <= rr_ptr_d;
      gnt       <= gnt_d;
      wr        <= wr_d;
      addr      <= addr_d;
      wdata     <= wdata_d;
      timer     <= timer_d;
      wr_strb   <= wr_strb_d;
      rd_strb   <= rd_strb_d;
      rsp_vld   <= rsp_vld_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      timeout   <= timeout_d;
    end
  end

  assign bus.rbus_addr_o    = addr;
  assign bus.rbus_wr_data_o = wdata;
  assign bus.rbus_wr_strb_o = wr_strb;
  assign bus.rbus_rd_strb_o = rd_strb;
  assign bus.rsp_vld        = rsp_vld;
  assign bus.rsp_err        = rsp_err;
  assign bus.rsp_rdata      = rsp_rdata;
  assign bus.timeout_o      = timeout;
  assign bus.busy_o         = (state != S_IDLE);
endmodule
